// File: rtl/keypad_lock_pkg.sv
// ----------------------------------------------------------------------------
// keypad_lock_pkg
// Shared definitions for the keypad code lock and its neighbours.
//   lock_state_e : lock FSM state encoding (also driven out for the display)
//   KEY_STAR     : keypad code for '*', shared with the keypad driver mapping
//   KEY_HASH     : keypad code for '#', shared with the keypad driver mapping
//   is_digit()   : true for key codes 0..9
// ----------------------------------------------------------------------------
package keypad_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } lock_state_e;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ----------------------------------------------------------------------------
// ms_tick_gen
// Free-running prescaler emitting a single-cycle pulse every CLK_HZ/1000
// clocks, i.e. once per millisecond. Shared by the timed blocks of the system.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   tick_o : one-cycle pulse per millisecond
// ----------------------------------------------------------------------------
module ms_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    // A clock slower than 1 kHz degenerates to a tick on every cycle.
    localparam int DIV   = ((CLK_HZ / 1000) < 1) ? 1 : (CLK_HZ / 1000);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] count_q;
    logic             atTerminal;

    assign atTerminal = (count_q == CNT_W'(DIV - 1));
    assign tick_o     = atTerminal;

    // Count 0..DIV-1 and wrap; the tick is the terminal count itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (atTerminal) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_code_lock.sv
// ----------------------------------------------------------------------------
// keypad_code_lock
// Collects BCD digits from the keypad driver, checks them against a stored
// code and manages unlock, failure counting, lockout and code changes.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   key_value_i        : key code (0-9 digit, 10 '*', 11 '#'), valid with key_valid_i
//   key_valid_i        : single-cycle key event
//   set_mode_i         : while OPEN, digit entry rewrites the stored code
//   entry_bcd_o        : entry buffer, newest digit in the low nibble
//   entry_len_o        : number of digits entered
//   unlocked_o         : high in OPEN
//   locked_out_o       : high in LOCKOUT
//   fail_cnt_o         : consecutive failure count
//   evt_ok_o, evt_fail_o, evt_code_set_o : single-cycle event pulses
//   state_o            : current state for the display
// ----------------------------------------------------------------------------
module keypad_code_lock
    import keypad_lock_pkg::*;
#(
    parameter int                    DIGITS           = 4,
    parameter int                    CLK_HZ           = 50_000_000,
    parameter int                    ENTRY_TIMEOUT_MS = 5000,
    parameter int                    OPEN_MS          = 3000,
    parameter int                    LOCK_MS          = 10000,
    parameter int                    MAX_FAIL         = 3,
    parameter logic [4*DIGITS-1:0]   DEFAULT_CODE     = 16'h1234
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [3:0]                      key_value_i,
    input  logic                            key_valid_i,
    input  logic                            set_mode_i,
    output logic [4*DIGITS-1:0]             entry_bcd_o,
    output logic [$clog2(DIGITS+1)-1:0]     entry_len_o,
    output logic                            unlocked_o,
    output logic                            locked_out_o,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt_o,
    output logic                            evt_ok_o,
    output logic                            evt_fail_o,
    output logic                            evt_code_set_o,
    output logic [1:0]                      state_o
);

    localparam int BUF_W  = 4 * DIGITS;
    localparam int LEN_W  = $clog2(DIGITS + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int MAX_MS_A = (ENTRY_TIMEOUT_MS > OPEN_MS) ? ENTRY_TIMEOUT_MS : OPEN_MS;
    localparam int MAX_MS   = (MAX_MS_A > LOCK_MS) ? MAX_MS_A : LOCK_MS;
    localparam int TMR_W    = $clog2(MAX_MS + 1);

    lock_state_e        state_q;
    logic [BUF_W-1:0]   entry_q;
    logic [LEN_W-1:0]   len_q;
    logic [BUF_W-1:0]   code_q;
    logic [FAIL_W-1:0]  fail_q;
    logic [TMR_W-1:0]   tmr_q;
    logic               unlocked_q;
    logic               lockedOut_q;
    logic               evtOk_q;
    logic               evtFail_q;
    logic               evtCodeSet_q;

    logic               msTick;
    logic               expire;
    logic               keyDigit;
    logic               keyStar;
    logic               keyHash;
    logic               bufFull;
    logic               codeMatch;
    logic               lastFail;
    logic [BUF_W-1:0]   shiftedEntry;

    ms_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (msTick)
    );

    // The shared ms counter expires on the tick that would take it from 1
    // to 0; with a free-running tick this lands within -1 ms of the load value.
    assign expire       = msTick && (tmr_q == TMR_W'(1));
    assign keyDigit     = is_digit(key_value_i);
    assign keyStar      = (key_value_i == KEY_STAR);
    assign keyHash      = (key_value_i == KEY_HASH);
    assign bufFull      = (len_q == LEN_W'(DIGITS));
    assign codeMatch    = bufFull && (entry_q == code_q);
    assign lastFail     = ((fail_q + FAIL_W'(1)) == FAIL_W'(MAX_FAIL));
    assign shiftedEntry = BUF_W'(entry_q << 4) | BUF_W'(key_value_i);

    // Lock FSM, entry buffer, stored code, failure count and the shared
    // timeout counter all live in one block so every output is a register.
    // Later assignments override earlier defaults: pulses clear each cycle,
    // the timer free-runs down, and state-specific loads win over both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            entry_q      <= '0;
            len_q        <= '0;
            code_q       <= DEFAULT_CODE;
            fail_q       <= '0;
            tmr_q        <= '0;
            unlocked_q   <= 1'b0;
            lockedOut_q  <= 1'b0;
            evtOk_q      <= 1'b0;
            evtFail_q    <= 1'b0;
            evtCodeSet_q <= 1'b0;
        end else begin
            evtOk_q      <= 1'b0;
            evtFail_q    <= 1'b0;
            evtCodeSet_q <= 1'b0;
            if (msTick && (tmr_q != '0)) begin
                tmr_q <= tmr_q - TMR_W'(1);
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (key_valid_i) begin
                        if (keyDigit && !bufFull) begin
                            entry_q <= shiftedEntry;
                            len_q   <= len_q + LEN_W'(1);
                            state_q <= ST_ENTRY;
                            tmr_q   <= TMR_W'(ENTRY_TIMEOUT_MS);
                        end else if (keyStar) begin
                            entry_q <= '0;
                            len_q   <= '0;
                        end
                    end
                end

                ST_ENTRY: begin
                    if (expire) begin
                        // Abandoned entry: discard quietly, not a failure.
                        entry_q <= '0;
                        len_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (key_valid_i) begin
                        // Any key, even one that is ignored, keeps entry alive.
                        tmr_q <= TMR_W'(ENTRY_TIMEOUT_MS);
                        if (keyDigit) begin
                            if (!bufFull) begin
                                entry_q <= shiftedEntry;
                                len_q   <= len_q + LEN_W'(1);
                            end
                        end else if (keyStar) begin
                            entry_q <= '0;
                            len_q   <= '0;
                            state_q <= ST_IDLE;
                        end else if (keyHash) begin
                            entry_q <= '0;
                            len_q   <= '0;
                            if (codeMatch) begin
                                evtOk_q    <= 1'b1;
                                fail_q     <= '0;
                                state_q    <= ST_OPEN;
                                unlocked_q <= 1'b1;
                                tmr_q      <= TMR_W'(OPEN_MS);
                            end else begin
                                evtFail_q <= 1'b1;
                                if (lastFail) begin
                                    fail_q      <= FAIL_W'(MAX_FAIL);
                                    state_q     <= ST_LOCKOUT;
                                    lockedOut_q <= 1'b1;
                                    tmr_q       <= TMR_W'(LOCK_MS);
                                end else begin
                                    fail_q  <= fail_q + FAIL_W'(1);
                                    state_q <= ST_IDLE;
                                end
                            end
                        end
                    end
                end

                ST_OPEN: begin
                    if (expire) begin
                        entry_q    <= '0;
                        len_q      <= '0;
                        state_q    <= ST_IDLE;
                        unlocked_q <= 1'b0;
                    end else if (key_valid_i) begin
                        if (!set_mode_i) begin
                            if (keyStar) begin
                                entry_q    <= '0;
                                len_q      <= '0;
                                state_q    <= ST_IDLE;
                                unlocked_q <= 1'b0;
                            end
                        end else if (keyDigit) begin
                            if (!bufFull) begin
                                entry_q <= shiftedEntry;
                                len_q   <= len_q + LEN_W'(1);
                            end
                        end else if (keyStar) begin
                            entry_q <= '0;
                            len_q   <= '0;
                        end else if (keyHash) begin
                            // A complete new code is committed and buys a
                            // fresh open window; a short one is just discarded.
                            if (bufFull) begin
                                code_q       <= entry_q;
                                evtCodeSet_q <= 1'b1;
                                tmr_q        <= TMR_W'(OPEN_MS);
                            end
                            entry_q <= '0;
                            len_q   <= '0;
                        end
                    end
                end

                ST_LOCKOUT: begin
                    if (expire) begin
                        fail_q      <= '0;
                        state_q     <= ST_IDLE;
                        lockedOut_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign entry_bcd_o    = entry_q;
    assign entry_len_o    = len_q;
    assign unlocked_o     = unlocked_q;
    assign locked_out_o   = lockedOut_q;
    assign fail_cnt_o     = fail_q;
    assign evt_ok_o       = evtOk_q;
    assign evt_fail_o     = evtFail_q;
    assign evt_code_set_o = evtCodeSet_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// ----------------------------------------------------------------------------
// tb_keypad_code_lock
// Self-checking bench for keypad_code_lock. A behavioural model keeps the
// entered digits and the stored code as queues of integers and tracks
// timeouts as absolute deadline cycle numbers; every cycle its view is
// compared against all DUT outputs. Directed scenarios are followed by
// randomized key traffic.
// ----------------------------------------------------------------------------
module tb_keypad_code_lock;

    localparam int DIGITS     = 4;
    localparam int ENTRY_MS   = 20;
    localparam int OPEN_T     = 30;
    localparam int LOCK_T     = 40;
    localparam int MAXF       = 3;

    localparam int S_IDLE  = 0;
    localparam int S_ENTRY = 1;
    localparam int S_OPEN  = 2;
    localparam int S_LOCK  = 3;

    localparam int K_STAR = 10;
    localparam int K_HASH = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_value = 4'd0;
    logic        key_valid = 1'b0;
    logic        set_mode = 1'b0;
    logic [15:0] entry_bcd;
    logic [2:0]  entry_len;
    logic        unlocked;
    logic        locked_out;
    logic [1:0]  fail_cnt;
    logic        evt_ok;
    logic        evt_fail;
    logic        evt_code_set;
    logic [1:0]  state_o;

    int assertCount = 0;
    int failCount   = 0;

    // Behavioural model state
    int mState;
    int mBuf[$];
    int mCode[$];
    int mFail;
    int mDeadline;
    int mCycle;
    bit mEvtOk, mEvtFail, mEvtSet;

    keypad_code_lock #(
        .DIGITS           (DIGITS),
        .CLK_HZ           (1000),
        .ENTRY_TIMEOUT_MS (ENTRY_MS),
        .OPEN_MS          (OPEN_T),
        .LOCK_MS          (LOCK_T),
        .MAX_FAIL         (MAXF),
        .DEFAULT_CODE     (16'h1234)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_value_i    (key_value),
        .key_valid_i    (key_valid),
        .set_mode_i     (set_mode),
        .entry_bcd_o    (entry_bcd),
        .entry_len_o    (entry_len),
        .unlocked_o     (unlocked),
        .locked_out_o   (locked_out),
        .fail_cnt_o     (fail_cnt),
        .evt_ok_o       (evt_ok),
        .evt_fail_o     (evt_fail),
        .evt_code_set_o (evt_code_set),
        .state_o        (state_o)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    // Safety net so the run can never hang
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int packBuf();
        int v = 0;
        foreach (mBuf[i]) v = v * 16 + mBuf[i];
        return v;
    endfunction

    task automatic modelReset();
        mState = S_IDLE;
        mBuf.delete();
        mCode = {1, 2, 3, 4};
        mFail = 0;
        mDeadline = 0;
        mEvtOk = 0;
        mEvtFail = 0;
        mEvtSet = 0;
    endtask

    task automatic modelGoIdle();
        mState = S_IDLE;
        mBuf.delete();
    endtask

    // One clock edge of the intended behaviour, given the sampled inputs.
    task automatic modelStep(input bit v, input int k, input bit sm);
        bit expire;
        bit match;
        mCycle++;
        mEvtOk = 0;
        mEvtFail = 0;
        mEvtSet = 0;
        expire = (mState != S_IDLE) && (mCycle == mDeadline);
        case (mState)
            S_IDLE: begin
                if (v && k <= 9) begin
                    mBuf.push_back(k);
                    mState = S_ENTRY;
                    mDeadline = mCycle + ENTRY_MS;
                end else if (v && k == K_STAR) begin
                    mBuf.delete();
                end
            end
            S_ENTRY: begin
                if (expire) begin
                    modelGoIdle();
                end else if (v) begin
                    mDeadline = mCycle + ENTRY_MS;
                    if (k <= 9) begin
                        if (mBuf.size() < DIGITS) mBuf.push_back(k);
                    end else if (k == K_STAR) begin
                        modelGoIdle();
                    end else if (k == K_HASH) begin
                        match = (mBuf.size() == DIGITS);
                        if (match) begin
                            for (int i = 0; i < DIGITS; i++)
                                if (mBuf[i] != mCode[i]) match = 0;
                        end
                        mBuf.delete();
                        if (match) begin
                            mEvtOk = 1;
                            mFail = 0;
                            mState = S_OPEN;
                            mDeadline = mCycle + OPEN_T;
                        end else begin
                            mEvtFail = 1;
                            if (mFail + 1 == MAXF) begin
                                mFail = MAXF;
                                mState = S_LOCK;
                                mDeadline = mCycle + LOCK_T;
                            end else begin
                                mFail = mFail + 1;
                                mState = S_IDLE;
                            end
                        end
                    end
                end
            end
            S_OPEN: begin
                if (expire) begin
                    modelGoIdle();
                end else if (v) begin
                    if (!sm) begin
                        if (k == K_STAR) modelGoIdle();
                    end else if (k <= 9) begin
                        if (mBuf.size() < DIGITS) mBuf.push_back(k);
                    end else if (k == K_STAR) begin
                        mBuf.delete();
                    end else if (k == K_HASH) begin
                        if (mBuf.size() == DIGITS) begin
                            mCode = mBuf;
                            mEvtSet = 1;
                            mDeadline = mCycle + OPEN_T;
                        end
                        mBuf.delete();
                    end
                end
            end
            default: begin
                if (expire) begin
                    mFail = 0;
                    mState = S_IDLE;
                end
            end
        endcase
    endtask

    task automatic compareAll();
        checkOutput("state",      32'(state_o),      32'(mState));
        checkOutput("entryBcd",   32'(entry_bcd),    32'(packBuf()));
        checkOutput("entryLen",   32'(entry_len),    32'(mBuf.size()));
        checkOutput("unlocked",   32'(unlocked),     32'(mState == S_OPEN));
        checkOutput("lockedOut",  32'(locked_out),   32'(mState == S_LOCK));
        checkOutput("failCnt",    32'(fail_cnt),     32'(mFail));
        checkOutput("evtOk",      32'(evt_ok),       32'(mEvtOk));
        checkOutput("evtFail",    32'(evt_fail),     32'(mEvtFail));
        checkOutput("evtCodeSet", 32'(evt_code_set), 32'(mEvtSet));
    endtask

    // Drive one cycle of input on the falling edge, step the model on the
    // rising edge, then compare shortly after it.
    task automatic applyStimulus(input bit v, input int k);
        @(negedge clk);
        key_valid = v;
        key_value = 4'(k);
        @(posedge clk);
        modelStep(v, k, set_mode);
        #1;
        key_valid = 1'b0;
        compareAll();
    endtask

    task automatic pressKey(input int k);
        applyStimulus(1'b1, k);
        applyStimulus(1'b0, 0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0);
    endtask

    task automatic typeDigits(input int a, input int b, input int c, input int d);
        pressKey(a);
        pressKey(b);
        pressKey(c);
        pressKey(d);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        key_valid = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        int codeCopy[$];

        modelReset();
        mCycle = 0;
        #12;
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;

        // Correct code opens for exactly OPEN_T cycles
        typeDigits(1, 2, 3, 4);
        applyStimulus(1'b1, K_HASH);
        checkOutput("okPulse", 32'(evt_ok), 32'd1);
        idleCycles(OPEN_T - 1);
        checkOutput("openLastCycle", 32'(unlocked), 32'd1);
        idleCycles(1);
        checkOutput("openExpired", 32'(state_o), 32'(S_IDLE));

        // Three wrong codes lead to lockout; keys are ignored while locked
        for (int n = 1; n <= MAXF; n++) begin
            typeDigits(1, 2, 3, 5);
            applyStimulus(1'b1, K_HASH);
            checkOutput("failPulse", 32'(evt_fail), 32'd1);
            checkOutput("failStep", 32'(fail_cnt), 32'(n));
        end
        checkOutput("lockedOut", 32'(locked_out), 32'd1);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b1, K_HASH);
        idleCycles(LOCK_T - 6);
        checkOutput("lockLastCycle", 32'(locked_out), 32'd1);
        idleCycles(1);
        checkOutput("lockReleased", 32'(state_o), 32'(S_IDLE));
        checkOutput("lockFailClr", 32'(fail_cnt), 32'd0);

        // Overfilled buffer drops the fifth digit; '*' clears
        typeDigits(9, 8, 7, 6);
        pressKey(5);
        checkOutput("fullBcd", 32'(entry_bcd), 32'h9876);
        checkOutput("fullLen", 32'(entry_len), 32'd4);
        pressKey(K_STAR);
        checkOutput("starClear", 32'(entry_bcd), 32'd0);
        checkOutput("starIdle", 32'(state_o), 32'(S_IDLE));

        // Short entry counts as a failure; an idle timeout does not
        pressKey(7);
        applyStimulus(1'b1, K_HASH);
        checkOutput("shortFail", 32'(fail_cnt), 32'd1);
        pressKey(1);
        applyStimulus(1'b1, 2);
        idleCycles(ENTRY_MS - 1);
        checkOutput("entryAlive", 32'(state_o), 32'(S_ENTRY));
        idleCycles(1);
        checkOutput("entryTimeout", 32'(state_o), 32'(S_IDLE));
        checkOutput("timeoutBuf", 32'(entry_bcd), 32'd0);
        checkOutput("timeoutFail", 32'(fail_cnt), 32'd1);

        // Change the code while open, then verify old and new codes
        typeDigits(1, 2, 3, 4);
        applyStimulus(1'b1, K_HASH);
        set_mode = 1'b1;
        typeDigits(5, 6, 7, 8);
        applyStimulus(1'b1, K_HASH);
        checkOutput("codeSetPulse", 32'(evt_code_set), 32'd1);
        set_mode = 1'b0;
        pressKey(K_STAR);
        checkOutput("relock", 32'(state_o), 32'(S_IDLE));
        typeDigits(5, 6, 7, 8);
        applyStimulus(1'b1, K_HASH);
        checkOutput("newCodeOk", 32'(evt_ok), 32'd1);
        pressKey(K_STAR);
        typeDigits(1, 2, 3, 4);
        applyStimulus(1'b1, K_HASH);
        checkOutput("oldCodeFail", 32'(evt_fail), 32'd1);

        // Key arriving on the OPEN expiry edge is dropped
        typeDigits(5, 6, 7, 8);
        applyStimulus(1'b1, K_HASH);
        set_mode = 1'b1;
        idleCycles(OPEN_T - 1);
        applyStimulus(1'b1, 7);
        checkOutput("expiryWinsState", 32'(state_o), 32'(S_IDLE));
        checkOutput("expiryWinsBuf", 32'(entry_len), 32'd0);
        set_mode = 1'b0;

        // Reset mid-entry restores the default code
        pressKey(5);
        pressKey(6);
        pulseReset();
        checkOutput("resetState", 32'(state_o), 32'(S_IDLE));
        typeDigits(1, 2, 3, 4);
        applyStimulus(1'b1, K_HASH);
        checkOutput("defaultCodeOk", 32'(evt_ok), 32'd1);
        pressKey(K_STAR);

        // Randomized key traffic against the model
        for (int i = 0; i < 1200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                set_mode = ~set_mode;
            end
            if (r < 12) begin
                codeCopy = mCode;
                foreach (codeCopy[j]) applyStimulus(1'b1, codeCopy[j]);
                applyStimulus(1'b1, K_HASH);
            end else if (r < 45) begin
                applyStimulus(1'b1, $urandom_range(0, 15));
            end else begin
                applyStimulus(1'b0, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
